inst_cache_dm: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache between the CPU core's ROM port
//  (rom_ce_o/rom_addr_o -> rom_data_i) and a variable-latency instruction bus (req/ack).
//  On a hit it returns the instruction in the same cycle. On a miss it raises stallreq_o,

---
 rtl/inst_cache_dm.sv | 188 ++++++++++++++++++
 tb/tb_inst_cache_dm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache_dm.sv
// ---------------------------------------------------------------------------
// inst_cache_dm
//   Direct-mapped instruction cache, one 32-bit word per line, placed between
//   the core's ROM fetch port and a variable-latency read bus (req/ack).
//   A hit returns the instruction in the same cycle. A miss stalls the core,
//   fetches the word over the bus and fills the line. A bus that never acks
//   is abandoned after TIMEOUT cycles: a NOP (0) is delivered and err_o pulses.
//
// Parameters
//   IDX_W    index bits, 2**IDX_W lines
//   TIMEOUT  request cycles without ack before the fetch is abandoned (>=2)
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous, active-low reset
//   cpu_ce_i    fetch enable from the core
//   cpu_addr_i  fetch byte address (bits [1:0] ignored)
//   cpu_inst_o  instruction to the core
//   stallreq_o  high while the current fetch is not served
//   flush_i     invalidate all lines (1-cycle pulse)
//   bus_req_o   bus read request, held until ack or timeout
//   bus_addr_o  word-aligned bus read address
//   bus_ack_i   bus read data valid
//   bus_data_i  bus read data
//   err_o       1-cycle pulse: fetch timed out, NOP delivered
//   miss_cnt_o  saturating miss counter
// ---------------------------------------------------------------------------
module inst_cache_dm #(
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_inst_o,
  output logic        stallreq_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_data_i,
  output logic        err_o,
  output logic [15:0] miss_cnt_o
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = 30 - IDX_W;
  localparam int CNT_W   = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]         state;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [31:0]        data_mem [ENTRIES];
  logic [29:0]        req_word;
  logic [CNT_W-1:0]   to_cnt;
  logic               drop;
  logic               byp_vld;
  logic [31:0]        byp_data;

  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               line_hit;
  logic               byp_hit;
  logic               hit;
  logic               miss;
  logic               ack_in_req;
  logic               timed_out;
  logic               do_fill;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign lk_idx   = cpu_addr_i[IDX_W+1:2];
  assign lk_tag   = cpu_addr_i[31:IDX_W+2];
  assign fill_idx = req_word[IDX_W-1:0];
  assign fill_tag = req_word[29:IDX_W];

  // The word just returned by the bus is served straight from a holding
  // register for one cycle, so the stall ends even when a flush dropped the fill.
  assign line_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign byp_hit  = byp_vld && (cpu_addr_i[31:2] == req_word);
  assign hit      = (state == S_IDLE) && cpu_ce_i && (line_hit || byp_hit);
  assign miss     = (state == S_IDLE) && cpu_ce_i && !(line_hit || byp_hit);

  // Ack beats a simultaneous timeout; flush beats a simultaneous ack.
  assign ack_in_req = (state == S_REQ) && bus_ack_i;
  assign timed_out  = (state == S_REQ) && !bus_ack_i && (to_cnt == CNT_W'(TIMEOUT - 1));
  assign do_fill    = ack_in_req && !drop && !flush_i;

  assign bus_addr_o = {req_word, 2'b00};

  always_comb begin
    cpu_inst_o = 32'h0;
    stallreq_o = 1'b0;
    if (cpu_ce_i) begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            cpu_inst_o = byp_hit ? byp_data : data_mem[lk_idx];
          end else begin
            stallreq_o = 1'b1;
          end
        end
        S_REQ:   stallreq_o = 1'b1;
        default: ;
      endcase
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      valid      <= '0;
      bus_req_o  <= 1'b0;
      req_word   <= '0;
      err_o      <= 1'b0;
      miss_cnt_o <= 16'h0;
      to_cnt     <= '0;
      drop       <= 1'b0;
      byp_vld    <= 1'b0;
    end else begin
      err_o   <= 1'b0;
      byp_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss) begin
            state      <= S_REQ;
            bus_req_o  <= 1'b1;
            req_word   <= cpu_addr_i[31:2];
            miss_cnt_o <= sat_inc16(miss_cnt_o);
            to_cnt     <= '0;
            drop       <= 1'b0;
          end
        end
        S_REQ: begin
          if (bus_ack_i) begin
            state     <= S_IDLE;
            bus_req_o <= 1'b0;
            to_cnt    <= '0;
            drop      <= 1'b0;
            byp_vld   <= 1'b1;
          end else if (timed_out) begin
            state     <= S_ERR;
            bus_req_o <= 1'b0;
            err_o     <= 1'b1;
            to_cnt    <= '0;
            drop      <= 1'b0;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
            if (flush_i) drop <= 1'b1;
          end
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (flush_i) begin
        valid <= '0;
      end else if (do_fill) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Line storage and bypass data
  always_ff @(posedge clk) begin
    if (do_fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus_data_i;
    end
    if (ack_in_req) begin
      byp_data <= bus_data_i;
    end
  end

endmodule

// File: tb/tb_inst_cache_dm.sv
module tb_inst_cache_dm;

  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int ENT     = 2 ** IDX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ce = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_inst;
  logic        stallreq;
  logic        flush = 1'b0;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_data = 32'h0;
  logic        err;
  logic [15:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what each line currently holds, by line number.
  bit          m_valid [ENT];
  logic [29:0] m_word  [ENT];
  logic [31:0] m_data  [ENT];
  int          m_miss;

  always #5 clk = ~clk;

  inst_cache_dm #(.IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce),
    .cpu_addr_i (cpu_addr),
    .cpu_inst_o (cpu_inst),
    .stallreq_o (stallreq),
    .flush_i    (flush),
    .bus_req_o  (bus_req),
    .bus_addr_o (bus_addr),
    .bus_ack_i  (bus_ack),
    .bus_data_i (bus_data),
    .err_o      (err),
    .miss_cnt_o (miss_cnt)
  );

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
  endfunction

  // One complete fetch with the bench acting as the bus slave.
  // lat: request cycles without ack before ack; flush_at: request cycle to
  // pulse flush (-1 none); no_ack: never ack.
  task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] bdata,
                       input int flush_at, input bit no_ack);
    int          idx;
    logic [29:0] wa;
    bit          exp_hit;
    int          stalls, reqc, n, exp_stalls, exp_reqc;
    bit          served;
    logic [31:0] got, exp_inst;
    logic        got_err, exp_err;
    idx     = int'(addr[IDX_W+1:2]);
    wa      = addr[31:2];
    exp_hit = m_valid[idx] && (m_word[idx] == wa);
    stalls  = 0; reqc = 0; n = 0; served = 1'b0; got = 32'h0; got_err = 1'b0;
    cpu_ce   = 1'b1;
    cpu_addr = addr;
    while (!served && n < TIMEOUT + 20) begin
      bus_ack  = bus_req && !no_ack && (reqc == lat);
      bus_data = bdata;
      flush    = bus_req && (reqc == flush_at);
      @(negedge clk);
      if (bus_req && reqc == 0) check32($sformatf("bus_addr@%h", addr), bus_addr, {wa, 2'b00});
      if (stallreq) stalls++;
      else begin
        served  = 1'b1;
        got     = cpu_inst;
        got_err = err;
      end
      if (bus_req) reqc++;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      flush   = 1'b0;
      n++;
    end
    if (exp_hit) begin
      exp_stalls = 0; exp_reqc = 0; exp_inst = m_data[idx]; exp_err = 1'b0;
    end else begin
      if (m_miss < 65535) m_miss++;
      if (no_ack) begin
        exp_stalls = TIMEOUT + 1; exp_reqc = TIMEOUT; exp_inst = 32'h0; exp_err = 1'b1;
      end else begin
        exp_stalls = lat + 2; exp_reqc = lat + 1; exp_inst = bdata; exp_err = 1'b0;
      end
      if (flush_at >= 0 && flush_at < exp_reqc) model_clear();
      else if (!no_ack) begin
        m_valid[idx] = 1'b1;
        m_word[idx]  = wa;
        m_data[idx]  = bdata;
      end
    end
    check32($sformatf("served@%h", addr), 32'(served), 32'd1);
    check32($sformatf("stalls@%h", addr), stalls, exp_stalls);
    check32($sformatf("req_cycles@%h", addr), reqc, exp_reqc);
    check32($sformatf("inst@%h", addr), got, exp_inst);
    check32($sformatf("err@%h", addr), 32'(got_err), 32'(exp_err));
    check32($sformatf("miss_cnt@%h", addr), 32'(miss_cnt), m_miss);
  endtask

  task automatic flush_idle();
    cpu_ce = 1'b0;
    flush  = 1'b1;
    @(negedge clk);
    check32("flush_idle_inst", cpu_inst, 32'h0);
    check32("flush_idle_stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [31:0] a;
    int          lat, r, fa, base;
    bit          na;

    model_clear();
    m_miss = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check32("rst_bus_req", 32'(bus_req), 32'd0);
    check32("rst_bus_addr", bus_addr, 32'h0);
    check32("rst_err", 32'(err), 32'd0);
    check32("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    check32("rst_inst", cpu_inst, 32'h0);
    check32("rst_stall", 32'(stallreq), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // First miss, refetch hit, conflict miss, re-miss
    fetch(32'h0000_0000, 3, 32'h3401_0001, -1, 1'b0);
    fetch(32'h0000_0000, 0, 32'h0, -1, 1'b0);
    fetch(32'h0000_0040, 1, 32'h2402_0005, -1, 1'b0);
    fetch(32'h0000_0000, 2, 32'h3401_0001, -1, 1'b0);
    check32("miss_cnt_three", 32'(miss_cnt), 32'd3);

    // Fetch disabled on a valid line: nothing returned, no stall
    cpu_ce = 1'b0;
    cpu_addr = 32'h0;
    @(negedge clk);
    check32("ce0_inst", cpu_inst, 32'h0);
    check32("ce0_stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;

    // Timeout, then the same address misses again
    fetch(32'h0000_0100, 0, 32'h0, -1, 1'b1);
    fetch(32'h0000_0100, 1, 32'h1111_2222, -1, 1'b0);

    // Ack on the last allowed cycle wins over the timeout
    fetch(32'h0000_0200, TIMEOUT - 1, 32'hCAFE_0200, -1, 1'b0);

    // Flush during request drops the fill and invalidates older lines
    fetch(32'h0000_0004, 1, 32'h0000_4444, -1, 1'b0);
    fetch(32'h0000_0008, 2, 32'hDEAD_BEEF, 1, 1'b0);
    fetch(32'h0000_0008, 0, 32'hDEAD_BEEF, -1, 1'b0);
    fetch(32'h0000_0000, 0, 32'h3401_0001, -1, 1'b0);
    fetch(32'h0000_0004, 0, 32'h0000_4444, -1, 1'b0);
    // Flush on the ack cycle itself
    fetch(32'h0000_000C, 1, 32'h0C0C_0C0C, 1, 1'b0);
    fetch(32'h0000_000C, 0, 32'h0C0C_0C0C, -1, 1'b0);

    // Fetch enable drops during the request: the line is still filled
    cpu_ce = 1'b1;
    cpu_addr = 32'h0000_0E40;
    @(negedge clk);
    check32("ce_fall_miss_stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    cpu_ce = 1'b0;
    @(negedge clk);
    check32("ce_fall_req", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    bus_ack = 1'b1;
    bus_data = 32'h0E40_0E40;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    m_miss++;
    m_valid[0] = 1'b1; m_word[0] = 30'h390; m_data[0] = 32'h0E40_0E40;
    fetch(32'h0000_0E40, 0, 32'h0, -1, 1'b0);

    // Reset in the middle of a request
    cpu_ce = 1'b1;
    cpu_addr = 32'h0000_0F00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check32("midreq_rst_bus_req", 32'(bus_req), 32'd0);
    check32("midreq_rst_miss_cnt", 32'(miss_cnt), 32'd0);
    check32("midreq_rst_bus_addr", bus_addr, 32'h0);
    bus_ack = 1'b1;
    bus_data = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    rst = 1'b1;
    model_clear();
    m_miss = 0;
    fetch(32'h0000_0F00, 0, 32'h0F00_0001, -1, 1'b0);
    fetch(32'h0000_0E40, 0, 32'h0E40_0E40, -1, 1'b0);

    // Stream 0x0..0x3C twice with single-cycle ack
    flush_idle();
    base = m_miss;
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), 1, 32'h5000_0000 + 32'(i), -1, 1'b0);
    check32("stream_pass1_misses", 32'(miss_cnt), base + 16);
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), 1, 32'h0, -1, 1'b0);
    check32("stream_pass2_misses", 32'(miss_cnt), base + 16);

    // Randomized traffic over a small address set so lines conflict and hit
    for (int t = 0; t < 300; t++) begin
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      lat = $urandom_range(0, 4);
      r   = $urandom_range(0, 99);
      na  = (r >= 97);
      fa  = -1;
      if (r < 10) fa = $urandom_range(0, lat);
      if (na && r[0]) fa = $urandom_range(0, TIMEOUT - 1);
      if (r >= 93 && r < 95) flush_idle();
      fetch(a, lat, $urandom, fa, na);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
